// File: rtl/mdc_pkg.sv
// Shared types and constants for the MDC FFT front end.
package mdc_pkg;

  localparam int CPLX_W    = 64;
  localparam int PART_W    = 32;
  localparam int MDC_N_FFT = 4;
  localparam int ADDR_W    = $clog2(MDC_N_FFT);

  typedef struct packed {
    logic [PART_W-1:0] re;
    logic [PART_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rd_state_t;

endpackage

// File: rtl/mdc_pp_buffer.sv
// Two-bank frame store: one write port, paired reads at k and k+N_FFT/2,
// and a full flag per bank.
module mdc_pp_buffer
  import mdc_pkg::*;
#(
  parameter  int N_FFT = MDC_N_FFT,
  parameter  int DW    = CPLX_W,
  localparam int AW    = $clog2(N_FFT)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          set_full,
  input  logic          rd_bank,
  input  logic [AW-2:0] rd_idx,
  input  logic          clr_full,
  output logic [DW-1:0] rd_lo,
  output logic [DW-1:0] rd_hi,
  output logic [1:0]    full
);

  logic [DW-1:0] mem [2*N_FFT];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Upper half of the frame is the same index with the address MSB set.
  assign rd_lo = mem[{rd_bank, 1'b0, rd_idx}];
  assign rd_hi = mem[{rd_bank, 1'b1, rd_idx}];

  // Writer only sets a bank it sees empty, reader only clears a bank it sees
  // full, so both updates in one cycle always target different banks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full <= 2'b00;
    end else begin
      if (set_full) full[wr_bank] <= 1'b1;
      if (clr_full) full[rd_bank] <= 1'b0;
    end
  end

endmodule

// File: rtl/mdc_input_commutator.sv
// Frame buffer feeding the first MDC radix-2 stage with (x[k], x[k+N/2]) pairs.
// state | meaning
// IDLE  | waiting for a full bank with HALT low; first pair issues on exit
// EMIT  | issuing the remaining pairs of the current frame, one per cycle
module mdc_input_commutator
  import mdc_pkg::*;
#(
  parameter  int N_FFT = MDC_N_FFT,
  parameter  int DW    = CPLX_W,
  localparam int AW    = $clog2(N_FFT),
  localparam int HALF  = N_FFT / 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  input  logic [DW-1:0] IN_DATA,
  output logic          IN_READY,
  input  logic          HALT,
  output logic          OUT_VALID,
  output logic [DW-1:0] D0,
  output logic [DW-1:0] D1,
  output logic          SEL_MDCFFT,
  output logic          OUT_SOF,
  output logic          OUT_EOF
);

  logic          wr_bank;
  logic [AW-1:0] wr_cnt;
  logic          rd_bank;
  logic [AW-2:0] rd_cnt;
  rd_state_t     state, state_nxt;
  logic [1:0]    full;
  logic          hs, wr_last, fire, rd_last;
  logic [DW-1:0] rd_lo, rd_hi;

  assign IN_READY = !full[wr_bank];
  assign hs       = IN_VALID && IN_READY;
  assign wr_last  = hs && (wr_cnt == AW'(N_FFT - 1));

  mdc_pp_buffer #(.N_FFT(N_FFT), .DW(DW)) u_buf (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (hs),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_cnt),
    .wr_data  (IN_DATA),
    .set_full (wr_last),
    .rd_bank  (rd_bank),
    .rd_idx   (rd_cnt),
    .clr_full (rd_last),
    .rd_lo    (rd_lo),
    .rd_hi    (rd_hi),
    .full     (full)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
    end else if (hs) begin
      if (wr_last) begin
        wr_cnt  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

  // The IDLE exit cycle already issues pair 0 so the first pair lands two
  // cycles after the last write handshake.
  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    rd_last   = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank] && !HALT) begin
          fire      = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT:    fire = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (fire && (rd_cnt == (AW-1)'(HALF - 1))) begin
      rd_last   = 1'b1;
      state_nxt = (full[~rd_bank] && !HALT) ? EMIT : IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (rd_last) begin
        rd_cnt  <= '0;
        rd_bank <= ~rd_bank;
      end else if (fire) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || !fire) begin
      OUT_VALID  <= 1'b0;
      D0         <= '0;
      D1         <= '0;
      SEL_MDCFFT <= 1'b0;
      OUT_SOF    <= 1'b0;
      OUT_EOF    <= 1'b0;
    end else begin
      OUT_VALID  <= 1'b1;
      D0         <= rd_lo;
      D1         <= rd_hi;
      SEL_MDCFFT <= rd_cnt[0];
      OUT_SOF    <= (rd_cnt == '0);
      OUT_EOF    <= rd_last;
    end
  end

endmodule
